// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Round-robin share of the cacheline adaptor between L1 I/D caches.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] a_address,
    output logic [LINE_W-1:0] a_line_o,
    input  logic [LINE_W-1:0] a_line_i,
    output logic              a_read,
    output logic              a_write,
    input  logic              a_resp
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_I  = 2'd1;
    localparam logic [1:0] c_BUSY_D  = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    localparam logic c_OWN_I = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic [ADDR_W-1:0] r_lat_addr;
    logic              r_lat_we;
    logic [LINE_W-1:0] r_lat_wdata;

    logic w_i_req;
    logic w_d_req;
    logic w_any_req;
    logic w_grant_d;
    logic w_busy;

    assign w_i_req   = i_read;
    assign w_d_req   = d_read | d_write;
    assign w_any_req = w_i_req | w_d_req;
    // On a tie the side that was not served last wins.
    assign w_grant_d = w_d_req & (~w_i_req | (r_last_owner == c_OWN_I));
    assign w_busy    = (r_state == c_BUSY_I) | (r_state == c_BUSY_D);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_owner      <= c_OWN_I;
            r_last_owner <= c_OWN_D;
            r_lat_addr   <= '0;
            r_lat_we     <= 1'b0;
            r_lat_wdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_grant_d ? c_OWN_D : c_OWN_I;
                        r_lat_addr <= w_grant_d ? d_address : i_address;
                        // A simultaneous read+write from the dcache is a write.
                        r_lat_we   <= w_grant_d & d_write;
                        if (w_grant_d && d_write) begin
                            r_lat_wdata <= d_wdata;
                        end
                        r_state    <= w_grant_d ? c_BUSY_D : c_BUSY_I;
                    end
                end
                c_BUSY_I, c_BUSY_D: begin
                    if (a_resp) begin
                        r_last_owner <= r_owner;
                        r_state      <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign a_address = r_lat_addr;
    assign a_line_o  = r_lat_wdata;
    assign a_read    = w_busy & ~r_lat_we;
    assign a_write   = w_busy & r_lat_we;

    assign i_resp  = (r_state == c_BUSY_I) & a_resp;
    assign d_resp  = (r_state == c_BUSY_D) & a_resp;
    assign i_rdata = a_line_i;
    assign d_rdata = a_line_i;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed self-checking bench for cache_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    logic         clk;
    logic         reset_n;
    logic [31:0]  i_address;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_address;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  a_address;
    logic [255:0] a_line_o;
    logic [255:0] a_line_i;
    logic         a_read;
    logic         a_write;
    logic         a_resp;

    int n_pass;
    int n_total;

    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .a_address(a_address), .a_line_o(a_line_o), .a_line_i(a_line_i),
        .a_read(a_read), .a_write(a_write), .a_resp(a_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Waits for the grant, checks the adaptor request, answers after lat cycles
    // and checks the response routing and the release cycle.
    task automatic transact(input string tag, input bit own_d, input logic [31:0] addr,
                            input bit we, input logic [255:0] wdata,
                            input logic [255:0] rline, input int lat);
        int w;
        bit got;
        w = 0;
        got = 1'b0;
        while (w < 4 && !got) begin
            tick();
            w++;
            #2;
            got = a_read | a_write;
        end
        chk({tag, " grant_wait"}, 256'(w), 256'd1);
        if (own_d) begin
            d_wdata   = '0;
            d_address = '0;
        end else begin
            i_address = '0;
        end
        #2;
        chk({tag, " a_address"}, 256'(a_address), 256'(addr));
        chk({tag, " a_write"}, 256'(a_write), 256'(we));
        chk({tag, " a_read"}, 256'(a_read), 256'(!we));
        if (we) chk({tag, " a_line_o"}, a_line_o, wdata);
        repeat (lat - 1) tick();
        #2;
        chk({tag, " hold_req"}, 256'(a_read | a_write), 256'd1);
        chk({tag, " no_early_resp"}, 256'({i_resp, d_resp}), 256'd0);
        tick();
        a_resp   = 1'b1;
        a_line_i = rline;
        #2;
        chk({tag, " own_resp"}, 256'(own_d ? d_resp : i_resp), 256'd1);
        chk({tag, " other_resp"}, 256'(own_d ? i_resp : d_resp), 256'd0);
        chk({tag, " rdata"}, own_d ? d_rdata : i_rdata, rline);
        tick();
        a_resp = 1'b0;
        if (own_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        #2;
        chk({tag, " release_req"}, 256'({a_read, a_write}), 256'd0);
        chk({tag, " release_resp"}, 256'({i_resp, d_resp}), 256'd0);
        tick();
    endtask

    logic [255:0] c_A5;
    logic [255:0] c_W1;
    logic [255:0] c_W2;
    logic [255:0] c_W3;

    initial begin
        n_pass    = 0;
        n_total   = 0;
        c_A5      = {32{8'hA5}};
        c_W1      = {8{32'h11223344}};
        c_W2      = {8{32'hDEADBEEF}};
        c_W3      = {8{32'h0F0F5A5A}};
        reset_n   = 1'b0;
        i_address = '0;
        i_read    = 1'b0;
        d_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_wdata   = '0;
        a_line_i  = '0;
        a_resp    = 1'b0;

        tick();
        tick();
        #2;
        chk("reset a_read", 256'(a_read), 256'd0);
        chk("reset a_write", 256'(a_write), 256'd0);
        chk("reset resps", 256'({i_resp, d_resp}), 256'd0);
        chk("reset a_address", 256'(a_address), 256'd0);
        chk("reset a_line_o", a_line_o, 256'd0);
        reset_n = 1'b1;

        // Single icache read.
        i_read    = 1'b1;
        i_address = 32'h0000_1000;
        transact("t1_iread", 1'b0, 32'h0000_1000, 1'b0, '0, c_A5, 5);

        // Dcache writeback; wdata is scrambled by the task after grant.
        d_write   = 1'b1;
        d_address = 32'h0000_2000;
        d_wdata   = c_W1;
        transact("t2_dwrite", 1'b1, 32'h0000_2000, 1'b1, c_W1, c_A5, 3);

        // Tie out of reset, then continuous contention: I, D, I, D.
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        i_read    = 1'b1;
        i_address = 32'h0000_1100;
        d_read    = 1'b1;
        d_address = 32'h0000_2200;
        transact("t3_a_I", 1'b0, 32'h0000_1100, 1'b0, '0, c_W2, 2);
        i_read    = 1'b1;
        i_address = 32'h0000_1200;
        transact("t3_b_D", 1'b1, 32'h0000_2200, 1'b0, '0, c_W3, 2);
        d_read    = 1'b1;
        d_address = 32'h0000_2300;
        transact("t3_c_I", 1'b0, 32'h0000_1200, 1'b0, '0, c_A5, 1);
        transact("t3_d_D", 1'b1, 32'h0000_2300, 1'b0, '0, c_W2, 1);

        // Stray adaptor response while idle.
        a_resp = 1'b1;
        #2;
        chk("t4 idle resps", 256'({i_resp, d_resp}), 256'd0);
        tick();
        #2;
        chk("t4 idle req", 256'({a_read, a_write}), 256'd0);
        chk("t4 idle resps2", 256'({i_resp, d_resp}), 256'd0);
        a_resp    = 1'b0;
        i_read    = 1'b1;
        i_address = 32'h0000_1300;
        transact("t4_after", 1'b0, 32'h0000_1300, 1'b0, '0, c_W3, 2);

        // Reset while BUSY_D: last_owner returns to D so I wins the next tie.
        d_write   = 1'b1;
        d_address = 32'h0000_2000;
        d_wdata   = c_W2;
        tick();
        #2;
        chk("t5 busy_d a_write", 256'(a_write), 256'd1);
        reset_n   = 1'b0;
        i_read    = 1'b1;
        i_address = 32'h0000_1400;
        tick();
        reset_n = 1'b1;
        a_resp  = 1'b1;
        #2;
        chk("t5 post_reset a_write", 256'(a_write), 256'd0);
        chk("t5 post_reset a_read", 256'(a_read), 256'd0);
        chk("t5 post_reset resps", 256'({i_resp, d_resp}), 256'd0);
        a_resp = 1'b0;
        transact("t5_I", 1'b0, 32'h0000_1400, 1'b0, '0, c_A5, 2);
        transact("t5_D", 1'b1, 32'h0000_2000, 1'b1, c_W2, c_A5, 2);

        // Illegal read+write is handled as a write.
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'h0000_3000;
        d_wdata   = c_W3;
        transact("t6_rw", 1'b1, 32'h0000_3000, 1'b1, c_W3, c_W1, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
